meas_pair_scheduler: RTL and testbench
======================================

Name: meas_pair_scheduler

Overview:
Frame-level sequencer for the ECT digital demodulation path. It steps through every excitation/detection electrode pair, programs the analogue switch selects, waits a fixed number of excitation periods for settling, then enables the demod channel. It collects each I/Q result and hands it to the upload FIFO over a valid/ack handshake. It sits between the host command decoder and the demod controller / MAC datapath.

Parameters:
NElec, 12, number of electrodes (3..16); pairs per frame NPair = NElec*(NElec-1)/2
SettleP, 8'd4, Sync periods to wait after switch change before enabling demod (1..255)
TimeoutCyc, 16'd50000, max CLK cycles in WAIT_RES before a pair is flagged as failed

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-low
Start  in  1  1-cycle pulse; begins a frame when idle
Stop  in  1  level; aborts the frame at the next state boundary
Sync  in  1  1-cycle CLK-synchronous strobe, once per excitation period
DemodRdy  in  1  demod result ready, level, from demod controller
ResI  in  32  in-phase accumulator result
ResQ  in  32  quadrature accumulator result
OverFlow  in  1  ADC overflow indicator from demod controller
ExcSel  out  4  excitation electrode select
DetSel  out  4  detection electrode select
ChEn  out  1  demod channel enable
PairIdx  out  7  index of current/returned pair (0..NPair-1)
DataI  out  32  latched I result
DataQ  out  32  latched Q result
ResErr  out  2  bit0 timeout, bit1 overflow seen during pair
ResValid  out  1  result valid, held until ResAck
ResAck  in  1  consumer accepts result
FrameBusy  out  1  high from Start accept to frame end/abort
FrameDone  out  1  1-cycle pulse after last pair accepted

Behaviour:
- Reset (RST low, async): all outputs 0; state IDLE; counters 0.
- Pair order: Exc=0..NElec-2, Det=Exc+1..NElec-1, Det fastest; PairIdx increments by 1 per pair.
- IDLE: FrameBusy=0, ChEn=0. Start=1 -> Exc=0, Det=1, PairIdx=0, FrameBusy=1, -> SWITCH. Start while busy ignored.
- SWITCH (1 cycle): ExcSel/DetSel registered from Exc/Det; settle counter cleared; -> SETTLE.
- SETTLE: counts Sync strobes; when count reaches SettleP (on the Sync cycle itself) -> ENABLE. Pair 0 needs exactly SettleP Sync strobes after SWITCH.
- ENABLE: ChEn=1; timeout counter cleared; OvfSeen cleared; -> WAIT_RES.
- WAIT_RES: ChEn held 1; OvfSeen |= OverFlow each cycle; timeout counter +1 per cycle.
  - DemodRdy=1 -> latch ResI/ResQ into DataI/DataQ, ResErr={OvfSeen|OverFlow,0}, -> OUTPUT.
  - Counter reaches TimeoutCyc -> DataI=DataQ=0, ResErr={OvfSeen,1}, -> OUTPUT.
  - DemodRdy and timeout in the same cycle: DemodRdy wins (ResErr[0]=0).
- OUTPUT: ChEn=0 on entry (drops demod for the next pair); ResValid=1. DataI/DataQ/ResErr/PairIdx stable while ResValid=1. ResAck=1 with ResValid=1 -> ResValid=0 next cycle, -> NEXT. ResAck while ResValid=0 ignored.
- NEXT (1 cycle): if PairIdx==NPair-1 -> FrameDone pulse, FrameBusy=0, -> IDLE. Else advance Det (wrap: Exc+1, Det=Exc+2), PairIdx+1, -> SWITCH.
- Stop=1 checked in SWITCH, SETTLE, ENABLE, WAIT_RES and NEXT: -> IDLE, ChEn=0, FrameBusy=0, no FrameDone. In OUTPUT the pending result completes its handshake first, then the block goes to IDLE instead of NEXT. Selects keep their last value.
- Start and Stop together in IDLE: Stop wins; stay IDLE.
- Latency: minimum SWITCH-to-ChEn is SettleP Sync periods plus 1 cycle. ResValid asserts 1 cycle after DemodRdy is sampled.
- Widths: settle counter 8b, timeout counter 16b; PairIdx 7b covers NElec<=16 (120 pairs).

Test Plan:
1. NElec=4, SettleP=2, Start, DemodRdy 10 cycles after each ChEn, ResAck immediate -> 6 results, PairIdx 0..5, (Exc,Det) = (0,1)(0,2)(0,3)(1,2)(1,3)(2,3), single FrameDone, FrameBusy low afterwards.
2. ResAck withheld 20 cycles on pair 2 -> ResValid held, DataI/DataQ/PairIdx=2 stable, no SWITCH until ack.
3. DemodRdy never asserted, TimeoutCyc=100 -> ResValid at 100+1 cycles after ENABLE, ResErr=2'b01, Data=0; frame continues.
4. OverFlow 1-cycle pulse during WAIT_RES of pair 1 -> ResErr=2'b10 for pair 1 only.
5. Stop during SETTLE of pair 3 -> IDLE within 1 cycle, ChEn=0, no FrameDone. A new Start restarts at PairIdx 0.
6. RST asserted mid-WAIT_RES -> all outputs 0 immediately (async); after release the block stays IDLE until Start.

Source files
------------

// File: rtl/meas_pair_scheduler.sv
// meas_pair_scheduler: frame sequencer for the ECT demodulation path.
// Walks every excitation/detection electrode pair (Det fastest), programs the
// analogue switch selects, waits a number of Sync periods for settling,
// enables the demod channel, collects the I/Q result and offers it to the
// upload FIFO over a valid/ack handshake.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start_i         1-cycle pulse, begins a frame when idle
//   stop_i          level, aborts the frame at the next state boundary
//   sync_i          1-cycle strobe, once per excitation period
//   demod_rdy_i     demod result ready (level)
//   res_i_i/res_q_i in-phase / quadrature accumulator results
//   overflow_i      ADC overflow indicator
//   exc_sel_o       excitation electrode select
//   det_sel_o       detection electrode select
//   ch_en_o         demod channel enable
//   pair_idx_o      index of current/returned pair
//   data_i_o/data_q_o latched I/Q result
//   res_err_o       bit0 timeout, bit1 overflow seen during pair
//   res_valid_o     result valid, held until res_ack_i
//   res_ack_i       consumer accepts result
//   frame_busy_o    high from start accept to frame end/abort
//   frame_done_o    1-cycle pulse after the last pair is accepted
module meas_pair_scheduler #(
  parameter int unsigned N_ELEC      = 12,
  parameter logic [7:0]  SETTLE_P    = 8'd4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        sync_i,
  input  logic        demod_rdy_i,
  input  logic [31:0] res_i_i,
  input  logic [31:0] res_q_i,
  input  logic        overflow_i,
  output logic [3:0]  exc_sel_o,
  output logic [3:0]  det_sel_o,
  output logic        ch_en_o,
  output logic [6:0]  pair_idx_o,
  output logic [31:0] data_i_o,
  output logic [31:0] data_q_o,
  output logic [1:0]  res_err_o,
  output logic        res_valid_o,
  input  logic        res_ack_i,
  output logic        frame_busy_o,
  output logic        frame_done_o
);

  localparam int unsigned NPAIR     = N_ELEC * (N_ELEC - 1) / 2;
  localparam logic [6:0]  LAST_PAIR = 7'(NPAIR - 1);
  localparam logic [3:0]  LAST_ELEC = 4'(N_ELEC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWITCH,
    S_SETTLE,
    S_ENABLE,
    S_WAIT_RES,
    S_OUTPUT,
    S_NEXT
  } state_e;

  state_e      state_q;
  logic [3:0]  exc_q;
  logic [3:0]  det_q;
  logic [7:0]  settle_q;
  logic [15:0] to_q;
  logic        ovf_seen_q;

  logic [3:0]  exc_sel_q;
  logic [3:0]  det_sel_q;
  logic        ch_en_q;
  logic [6:0]  pair_idx_q;
  logic [31:0] data_i_q;
  logic [31:0] data_q_q;
  logic [1:0]  res_err_q;
  logic        res_valid_q;
  logic        busy_q;
  logic        frame_done_q;

  // Sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      exc_q        <= '0;
      det_q        <= '0;
      settle_q     <= '0;
      to_q         <= '0;
      ovf_seen_q   <= 1'b0;
      exc_sel_q    <= '0;
      det_sel_q    <= '0;
      ch_en_q      <= 1'b0;
      pair_idx_q   <= '0;
      data_i_q     <= '0;
      data_q_q     <= '0;
      res_err_q    <= '0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ch_en_q <= 1'b0;
          busy_q  <= 1'b0;
          // Stop has priority over a simultaneous Start.
          if (start_i && !stop_i) begin
            exc_q      <= 4'd0;
            det_q      <= 4'd1;
            pair_idx_q <= 7'd0;
            busy_q     <= 1'b1;
            state_q    <= S_SWITCH;
          end
        end

        S_SWITCH: begin
          if (stop_i) begin
            ch_en_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            exc_sel_q <= exc_q;
            det_sel_q <= det_q;
            settle_q  <= 8'd0;
            state_q   <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (stop_i) begin
            ch_en_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (sync_i) begin
            settle_q <= settle_q + 8'd1;
            // Leave on the Sync that completes the settle count.
            if (settle_q + 8'd1 == SETTLE_P) begin
              ch_en_q <= 1'b1;
              state_q <= S_ENABLE;
            end
          end
        end

        S_ENABLE: begin
          if (stop_i) begin
            ch_en_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            to_q       <= 16'd0;
            ovf_seen_q <= 1'b0;
            state_q    <= S_WAIT_RES;
          end
        end

        S_WAIT_RES: begin
          if (stop_i) begin
            ch_en_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            ovf_seen_q <= ovf_seen_q | overflow_i;
            to_q       <= to_q + 16'd1;
            // A ready result beats a coincident timeout.
            if (demod_rdy_i) begin
              data_i_q    <= res_i_i;
              data_q_q    <= res_q_i;
              res_err_q   <= {ovf_seen_q | overflow_i, 1'b0};
              res_valid_q <= 1'b1;
              ch_en_q     <= 1'b0;
              state_q     <= S_OUTPUT;
            end else if (to_q + 16'd1 == TIMEOUT_CYC) begin
              data_i_q    <= 32'd0;
              data_q_q    <= 32'd0;
              res_err_q   <= {ovf_seen_q, 1'b1};
              res_valid_q <= 1'b1;
              ch_en_q     <= 1'b0;
              state_q     <= S_OUTPUT;
            end
          end
        end

        S_OUTPUT: begin
          // The pending result always completes its handshake, even under Stop.
          if (res_ack_i && res_valid_q) begin
            res_valid_q <= 1'b0;
            if (stop_i) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_NEXT;
            end
          end
        end

        S_NEXT: begin
          if (stop_i) begin
            ch_en_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (pair_idx_q == LAST_PAIR) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            // Det runs fastest; on wrap the excitation moves up by one.
            if (det_q == LAST_ELEC) begin
              exc_q <= exc_q + 4'd1;
              det_q <= exc_q + 4'd2;
            end else begin
              det_q <= det_q + 4'd1;
            end
            pair_idx_q <= pair_idx_q + 7'd1;
            state_q    <= S_SWITCH;
          end
        end

        default: begin
          ch_en_q     <= 1'b0;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign exc_sel_o    = exc_sel_q;
  assign det_sel_o    = det_sel_q;
  assign ch_en_o      = ch_en_q;
  assign pair_idx_o   = pair_idx_q;
  assign data_i_o     = data_i_q;
  assign data_q_o     = data_q_q;
  assign res_err_o    = res_err_q;
  assign res_valid_o  = res_valid_q;
  assign frame_busy_o = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_meas_pair_scheduler.sv
// tb_meas_pair_scheduler: directed bench for meas_pair_scheduler with
// NElec=4, SettleP=2, TimeoutCyc=100 and a Sync strobe every 8 cycles.
module tb_meas_pair_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, stop_i, sync_i, demod_rdy_i, overflow_i, res_ack_i;
  logic [31:0] res_i_i, res_q_i;
  logic [3:0]  exc_sel_o, det_sel_o;
  logic        ch_en_o, res_valid_o, frame_busy_o, frame_done_o;
  logic [6:0]  pair_idx_o;
  logic [31:0] data_i_o, data_q_o;
  logic [1:0]  res_err_o;

  int n_vec    = 0;
  int n_err    = 0;
  int done_cnt = 0;

  meas_pair_scheduler #(
    .N_ELEC     (4),
    .SETTLE_P   (8'd2),
    .TIMEOUT_CYC(16'd100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .sync_i      (sync_i),
    .demod_rdy_i (demod_rdy_i),
    .res_i_i     (res_i_i),
    .res_q_i     (res_q_i),
    .overflow_i  (overflow_i),
    .exc_sel_o   (exc_sel_o),
    .det_sel_o   (det_sel_o),
    .ch_en_o     (ch_en_o),
    .pair_idx_o  (pair_idx_o),
    .data_i_o    (data_i_o),
    .data_q_o    (data_q_o),
    .res_err_o   (res_err_o),
    .res_valid_o (res_valid_o),
    .res_ack_i   (res_ack_i),
    .frame_busy_o(frame_busy_o),
    .frame_done_o(frame_done_o)
  );

  initial forever #5 clk = ~clk;

  // Sync strobe: one cycle high every 8 cycles.
  initial begin
    sync_i = 1'b0;
    forever begin
      repeat (7) @(negedge clk);
      sync_i = 1'b1;
      @(negedge clk);
      sync_i = 1'b0;
    end
  end

  always @(negedge clk) if (frame_done_o === 1'b1) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_i(input int p);
    return 32'h1111_0000 | 32'(p);
  endfunction

  function automatic logic [31:0] exp_q(input int p);
    return 32'h2222_0000 | 32'(p);
  endfunction

  // Waits for channel enable, plays the demod side and returns at the first
  // cycle res_valid_o is seen; lat counts cycles from the first cycle ch_en_o
  // is seen. rdy_dly < 1 means DemodRdy is never raised.
  task automatic do_pair(input int rdy_dly, input int ovf_at, input int p,
                         output bit ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 300; i++) begin
      if (ch_en_o === 1'b1) break;
      @(negedge clk);
    end
    if (ch_en_o !== 1'b1) return;
    for (int k = 0; k < 400; k++) begin
      demod_rdy_i = (rdy_dly >= 1) && (k == rdy_dly);
      overflow_i  = (k == ovf_at);
      res_i_i     = exp_i(p);
      res_q_i     = exp_q(p);
      @(negedge clk);
      if (res_valid_o === 1'b1) begin
        lat = k + 1;
        ok  = 1'b1;
        break;
      end
    end
    demod_rdy_i = 1'b0;
    overflow_i  = 1'b0;
  endtask

  task automatic do_ack();
    res_ack_i = 1'b1;
    @(negedge clk);
    res_ack_i = 1'b0;
  endtask

  task automatic start_frame();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic stop_frame();
    stop_i = 1'b1;
    repeat (2) @(negedge clk);
    stop_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [84:0] obs;
    rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; demod_rdy_i = 1'b0;
    overflow_i = 1'b0; res_ack_i = 1'b0; res_i_i = '0; res_q_i = '0;
    repeat (3) @(negedge clk);
    obs = {exc_sel_o, det_sel_o, ch_en_o, pair_idx_o, data_i_o, data_q_o,
           res_err_o, res_valid_o, frame_busy_o, frame_done_o};
    n_vec++;
    if (obs !== 85'd0) begin
      n_err++; $display("FAIL reset_outputs got %h exp 0", obs);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_vec++;
    if ({frame_busy_o, ch_en_o} !== 2'b00) begin
      n_err++; $display("FAIL reset_idle got busy/chen %b exp 00", {frame_busy_o, ch_en_o});
    end
  endtask

  task automatic test_full_frame();
    logic [3:0] ex [6];
    logic [3:0] dt [6];
    bit ok;
    int lat;
    int d0;
    ex = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2};
    dt = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd3, 4'd3};
    d0 = done_cnt;
    start_frame();
    n_vec++;
    if (frame_busy_o !== 1'b1) begin
      n_err++; $display("FAIL frame_busy_start got %b exp 1", frame_busy_o);
    end
    for (int p = 0; p < 6; p++) begin
      do_pair(10, -1, p, ok, lat);
      n_vec++;
      if (!ok || lat != 11) begin
        n_err++; $display("FAIL frame_latency pair %0d got ok=%0d lat=%0d exp lat 11", p, ok, lat);
      end
      n_vec++;
      if ({exc_sel_o, det_sel_o} !== {ex[p], dt[p]}) begin
        n_err++; $display("FAIL frame_sel pair %0d got %h/%h exp %h/%h", p, exc_sel_o, det_sel_o, ex[p], dt[p]);
      end
      n_vec++;
      if (pair_idx_o !== 7'(p)) begin
        n_err++; $display("FAIL frame_idx got %0d exp %0d", pair_idx_o, p);
      end
      n_vec++;
      if ({data_i_o, data_q_o, res_err_o, ch_en_o} !== {exp_i(p), exp_q(p), 2'b00, 1'b0}) begin
        n_err++; $display("FAIL frame_data pair %0d got %h %h err %b chen %b exp %h %h err 00 chen 0",
                          p, data_i_o, data_q_o, res_err_o, ch_en_o, exp_i(p), exp_q(p));
      end
      do_ack();
      n_vec++;
      if (res_valid_o !== 1'b0) begin
        n_err++; $display("FAIL frame_ack_drop pair %0d got %b exp 0", p, res_valid_o);
      end
    end
    repeat (5) @(negedge clk);
    n_vec++;
    if (done_cnt - d0 != 1) begin
      n_err++; $display("FAIL frame_done_count got %0d exp 1", done_cnt - d0);
    end
    n_vec++;
    if (frame_busy_o !== 1'b0) begin
      n_err++; $display("FAIL frame_busy_end got %b exp 0", frame_busy_o);
    end
  endtask

  task automatic test_ack_hold();
    bit ok;
    int lat;
    int bad;
    int d0;
    logic [80:0] snap;
    d0 = done_cnt;
    start_frame();
    for (int p = 0; p < 2; p++) begin
      do_pair(4, -1, p, ok, lat);
      do_ack();
    end
    do_pair(4, -1, 2, ok, lat);
    n_vec++;
    if (!ok || pair_idx_o !== 7'd2 || data_i_o !== exp_i(2) || data_q_o !== exp_q(2)) begin
      n_err++; $display("FAIL hold_first got ok=%0d idx %0d data %h %h exp idx 2 data %h %h",
                        ok, pair_idx_o, data_i_o, data_q_o, exp_i(2), exp_q(2));
    end
    snap = {pair_idx_o, data_i_o, data_q_o, res_err_o, exc_sel_o, det_sel_o};
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (res_valid_o !== 1'b1 || ch_en_o !== 1'b0 ||
          {pair_idx_o, data_i_o, data_q_o, res_err_o, exc_sel_o, det_sel_o} !== snap)
        bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL hold_stable got %0d unstable cycles exp 0", bad);
    end
    do_ack();
    for (int p = 3; p < 6; p++) begin
      do_pair(4, -1, p, ok, lat);
      n_vec++;
      if (!ok || pair_idx_o !== 7'(p) || data_i_o !== exp_i(p)) begin
        n_err++; $display("FAIL hold_resume got ok=%0d idx %0d data %h exp idx %0d data %h",
                          ok, pair_idx_o, data_i_o, p, exp_i(p));
      end
      do_ack();
    end
    repeat (5) @(negedge clk);
    n_vec++;
    if (done_cnt - d0 != 1) begin
      n_err++; $display("FAIL hold_done got %0d exp 1", done_cnt - d0);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int lat;
    start_frame();
    do_pair(-1, -1, 0, ok, lat);
    n_vec++;
    if (!ok || lat != 101) begin
      n_err++; $display("FAIL timeout_latency got ok=%0d lat=%0d exp 101", ok, lat);
    end
    n_vec++;
    if ({res_err_o, data_i_o, data_q_o, pair_idx_o} !== {2'b01, 32'd0, 32'd0, 7'd0}) begin
      n_err++; $display("FAIL timeout_result got err %b data %h %h idx %0d exp err 01 data 0 0 idx 0",
                        res_err_o, data_i_o, data_q_o, pair_idx_o);
    end
    do_ack();
    do_pair(6, -1, 1, ok, lat);
    n_vec++;
    if (!ok || {res_err_o, pair_idx_o, data_i_o} !== {2'b00, 7'd1, exp_i(1)}) begin
      n_err++; $display("FAIL timeout_continue got ok=%0d err %b idx %0d data %h exp err 00 idx 1 data %h",
                        ok, res_err_o, pair_idx_o, data_i_o, exp_i(1));
    end
    do_ack();
    stop_frame();
    n_vec++;
    if (frame_busy_o !== 1'b0) begin
      n_err++; $display("FAIL timeout_stop got busy %b exp 0", frame_busy_o);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int lat;
    logic [1:0] exp_err [3];
    exp_err = '{2'b00, 2'b10, 2'b00};
    start_frame();
    for (int p = 0; p < 3; p++) begin
      do_pair(10, (p == 1) ? 3 : -1, p, ok, lat);
      n_vec++;
      if (!ok || res_err_o !== exp_err[p] || data_i_o !== exp_i(p)) begin
        n_err++; $display("FAIL overflow_err pair %0d got ok=%0d err %b data %h exp err %b data %h",
                          p, ok, res_err_o, data_i_o, exp_err[p], exp_i(p));
      end
      do_ack();
    end
    stop_frame();
  endtask

  task automatic test_stop_settle();
    bit ok;
    int lat;
    int d0;
    int bad;
    start_frame();
    for (int p = 0; p < 3; p++) begin
      do_pair(3, -1, p, ok, lat);
      do_ack();
    end
    for (int i = 0; i < 50; i++) begin
      if (exc_sel_o === 4'd1 && det_sel_o === 4'd2) break;
      @(negedge clk);
    end
    n_vec++;
    if ({exc_sel_o, det_sel_o, ch_en_o, frame_busy_o} !== {4'd1, 4'd2, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL stop_reach_settle got sel %h/%h chen %b busy %b exp 1/2 0 1",
                        exc_sel_o, det_sel_o, ch_en_o, frame_busy_o);
    end
    d0 = done_cnt;
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    n_vec++;
    if ({frame_busy_o, ch_en_o} !== 2'b00) begin
      n_err++; $display("FAIL stop_abort got busy/chen %b exp 00", {frame_busy_o, ch_en_o});
    end
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (frame_busy_o !== 1'b0 || ch_en_o !== 1'b0 || res_valid_o !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0 || done_cnt != d0) begin
      n_err++; $display("FAIL stop_stays_idle got bad=%0d done_delta=%0d exp 0 0", bad, done_cnt - d0);
    end
    start_i = 1'b1;
    stop_i  = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    stop_i  = 1'b0;
    n_vec++;
    if (frame_busy_o !== 1'b0) begin
      n_err++; $display("FAIL start_stop_same got busy %b exp 0", frame_busy_o);
    end
    repeat (30) @(negedge clk);
    n_vec++;
    if (ch_en_o !== 1'b0) begin
      n_err++; $display("FAIL start_stop_no_enable got chen %b exp 0", ch_en_o);
    end
    start_frame();
    do_pair(3, -1, 0, ok, lat);
    n_vec++;
    if (!ok || {pair_idx_o, exc_sel_o, det_sel_o} !== {7'd0, 4'd0, 4'd1}) begin
      n_err++; $display("FAIL restart_pair0 got ok=%0d idx %0d sel %h/%h exp 0 0/1",
                        ok, pair_idx_o, exc_sel_o, det_sel_o);
    end
    do_ack();
    stop_frame();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lat;
    int bad;
    logic [84:0] obs;
    start_frame();
    for (int i = 0; i < 300; i++) begin
      if (ch_en_o === 1'b1) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if ({ch_en_o, frame_busy_o, det_sel_o} !== {1'b1, 1'b1, 4'd1}) begin
      n_err++; $display("FAIL rst_mid_precond got chen %b busy %b det %h exp 1 1 1",
                        ch_en_o, frame_busy_o, det_sel_o);
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {exc_sel_o, det_sel_o, ch_en_o, pair_idx_o, data_i_o, data_q_o,
           res_err_o, res_valid_o, frame_busy_o, frame_done_o};
    n_vec++;
    if (obs !== 85'd0) begin
      n_err++; $display("FAIL rst_mid_async got %h exp 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (frame_busy_o !== 1'b0 || ch_en_o !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL rst_mid_idle got %0d busy cycles exp 0", bad);
    end
    start_frame();
    do_pair(5, -1, 0, ok, lat);
    n_vec++;
    if (!ok || lat != 6 || pair_idx_o !== 7'd0 || data_i_o !== exp_i(0)) begin
      n_err++; $display("FAIL rst_mid_restart got ok=%0d lat=%0d idx %0d data %h exp lat 6 idx 0 data %h",
                        ok, lat, pair_idx_o, data_i_o, exp_i(0));
    end
    do_ack();
    stop_frame();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_ack_hold();
    test_timeout();
    test_overflow();
    test_stop_settle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
